// File: rtl/extmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// extmem_ctrl_if
// Bundles the request, response and external memory bus signals of
// extmem_ctrl.
//   master : the controller (accepts requests, returns responses, drives
//            the external memory port)
//   slave  : its environment (requester, response consumer, memory pins)
// ---------------------------------------------------------------------------
interface extmem_ctrl_if;
  localparam int unsigned ADR_W = 13;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned BE_W  = 4;

  // request channel
  logic             req_valid;
  logic             req_ready;
  logic             req_rwb;
  logic             req_line;
  logic [ADR_W-1:0] req_adr;
  logic [DAT_W-1:0] req_wdata;
  logic [BE_W-1:0]  req_byteen;

  // response channel
  logic             resp_valid;
  logic [DAT_W-1:0] resp_data;
  logic             resp_last;
  logic             resp_err;

  // external memory port
  logic [ADR_W-1:0] mem_adr;
  logic [DAT_W-1:0] mem_wdata;
  logic             mem_wdata_oe;
  logic [DAT_W-1:0] mem_rdata;
  logic [BE_W-1:0]  mem_byteen;
  logic             mem_rwb;
  logic             mem_en;
  logic             mem_done;

  modport master (
    input  req_valid, req_rwb, req_line, req_adr, req_wdata, req_byteen,
    input  mem_rdata, mem_done,
    output req_ready,
    output resp_valid, resp_data, resp_last, resp_err,
    output mem_adr, mem_wdata, mem_wdata_oe, mem_byteen, mem_rwb, mem_en
  );

  modport slave (
    output req_valid, req_rwb, req_line, req_adr, req_wdata, req_byteen,
    output mem_rdata, mem_done,
    input  req_ready,
    input  resp_valid, resp_data, resp_last, resp_err,
    input  mem_adr, mem_wdata, mem_wdata_oe, mem_byteen, mem_rwb, mem_en
  );
endinterface

// File: rtl/extmem_ctrl.sv
// ---------------------------------------------------------------------------
// extmem_ctrl
// Request sequencer between cache/fetch logic and the external memory port.
// Accepts one request at a time: a byte-enabled single-word write, a
// single-word read, or an aligned 4-word line read. One beat completes per
// sampled mem_done; every completed beat returns a one-cycle response pulse.
//
// Ports
//   ph1      : system clock, rising edge
//   reset_b  : synchronous reset, active low
//   bus      : extmem_ctrl_if.master
//              req_*  : request (valid/ready, rwb, line, adr, wdata, byteen)
//              resp_* : response pulse (valid, data, last, err)
//              mem_*  : external bus (adr, wdata, wdata_oe, rdata, byteen,
//                       rwb, en, done)
//
// Optional feature
//   EXTMEM_CTRL_TIMEOUT_EN : when defined, a beat waiting more than
//   TIMEOUT_CYC cycles for mem_done is aborted with resp_err. When not
//   defined, resp_err is always 0 and a beat waits forever.
// ---------------------------------------------------------------------------
module extmem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic          ph1,
  input logic          reset_b,
  extmem_ctrl_if.master bus
);

  localparam int unsigned ADR_W  = 13;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t              state;
  logic                lat_rwb;
  logic                lat_line;
  logic [ADR_W-1:0]    lat_adr;
  logic [BEAT_W-1:0]   beat;
  logic                last_beat_c;

`ifdef EXTMEM_CTRL_TIMEOUT_EN
  localparam logic [WCNT_W-1:0] TO_LIMIT = WCNT_W'(TIMEOUT_CYC);
  logic [WCNT_W-1:0]   wcnt;
`else
  logic                unused_timeout_cyc;
  assign unused_timeout_cyc = ^WCNT_W'(TIMEOUT_CYC);
`endif

  // A single access, or beat 3 of a line, finishes the request.
  assign last_beat_c = !lat_line || (beat == BEAT_W'(3));

  // Request sequencer: state, latched request and all registered outputs.
  always_ff @(posedge ph1) begin
    if (!reset_b) begin
      state            <= S_IDLE;
      lat_rwb          <= 1'b1;
      lat_line         <= 1'b0;
      lat_adr          <= '0;
      beat             <= '0;
`ifdef EXTMEM_CTRL_TIMEOUT_EN
      wcnt             <= '0;
`endif
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_data    <= '0;
      bus.resp_last    <= 1'b0;
      bus.resp_err     <= 1'b0;
      bus.mem_adr      <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_wdata_oe <= 1'b0;
      bus.mem_byteen   <= '0;
      bus.mem_rwb      <= 1'b1;
      bus.mem_en       <= 1'b0;
    end else begin
      // response flags are single-cycle pulses
      bus.resp_valid <= 1'b0;
      bus.resp_last  <= 1'b0;
      bus.resp_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            state            <= S_XFER;
            bus.req_ready    <= 1'b0;
            lat_rwb          <= bus.req_rwb;
            // line is only meaningful for reads
            lat_line         <= bus.req_rwb & bus.req_line;
            beat             <= '0;
`ifdef EXTMEM_CTRL_TIMEOUT_EN
            wcnt             <= '0;
`endif
            // a line starts on its aligned first word
            if (bus.req_rwb && bus.req_line) begin
              lat_adr     <= {bus.req_adr[ADR_W-1:2], 2'b00};
              bus.mem_adr <= {bus.req_adr[ADR_W-1:2], 2'b00};
            end else begin
              lat_adr     <= bus.req_adr;
              bus.mem_adr <= bus.req_adr;
            end
            bus.mem_en       <= 1'b1;
            bus.mem_rwb      <= bus.req_rwb;
            bus.mem_wdata    <= bus.req_wdata;
            bus.mem_wdata_oe <= ~bus.req_rwb;
            bus.mem_byteen   <= bus.req_rwb ? BE_W'(0) : bus.req_byteen;
          end
        end

        S_XFER: begin
          if (bus.mem_done) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= lat_rwb ? bus.mem_rdata : DAT_W'(0);
            bus.resp_last  <= last_beat_c;
`ifdef EXTMEM_CTRL_TIMEOUT_EN
            wcnt           <= '0;
`endif
            if (last_beat_c) begin
              // memory commits whenever rwb=0, so release it immediately
              state            <= S_IDLE;
              bus.req_ready    <= 1'b1;
              bus.mem_en       <= 1'b0;
              bus.mem_rwb      <= 1'b1;
              bus.mem_wdata_oe <= 1'b0;
              bus.mem_byteen   <= '0;
            end else begin
              beat        <= beat + BEAT_W'(1);
              bus.mem_adr <= {lat_adr[ADR_W-1:2], beat + BEAT_W'(1)};
            end
          end
`ifdef EXTMEM_CTRL_TIMEOUT_EN
          else if (wcnt == TO_LIMIT) begin
            // abort the whole request with a single error response
            bus.resp_valid   <= 1'b1;
            bus.resp_data    <= '0;
            bus.resp_last    <= 1'b1;
            bus.resp_err     <= 1'b1;
            state            <= S_IDLE;
            bus.req_ready    <= 1'b1;
            bus.mem_en       <= 1'b0;
            bus.mem_rwb      <= 1'b1;
            bus.mem_wdata_oe <= 1'b0;
            bus.mem_byteen   <= '0;
            wcnt             <= '0;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
`endif
        end

        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.mem_en    <= 1'b0;
          bus.mem_rwb   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_extmem_ctrl
// Bench for extmem_ctrl: a behavioural external memory on the pins, a
// transaction-level reference model (expected response list per request,
// expected bus drive while a request is open) compared every cycle, and
// directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_extmem_ctrl;
  localparam int unsigned TIMEOUT_CYC = 255;
`ifdef EXTMEM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic ph1 = 1'b0;
  logic reset_b;

  extmem_ctrl_if bus ();

  extmem_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .ph1     (ph1),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 ph1 = ~ph1;

  int checks   = 0;
  int failures = 0;
  int n_resp   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external memory on the pins ----------------
  logic [31:0] bus_mem [0:8191];
  assign bus.mem_rdata = bus_mem[bus.mem_adr];

  always @(posedge ph1) begin
    if (bus.mem_rwb === 1'b0) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteen[b])
          bus_mem[bus.mem_adr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [0:8191];
  rsp_t        expq [$];
  bit          armed    = 1'b0;
  bit          m_active = 1'b0;
  bit          m_rwb, m_line;
  logic [12:0] m_adr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  int          m_beats;
  int unsigned m_wc;
  bit          pend     = 1'b0;
  bit          pend_err = 1'b0;

  // What each clock edge must do: accept, complete a beat, or time out.
  always @(posedge ph1) begin
    if (reset_b === 1'b0) begin
      armed    = 1'b1;
      m_active = 1'b0;
      expq.delete();
      pend     = 1'b0;
      pend_err = 1'b0;
      m_wc     = 0;
    end else if (armed) begin
      pend     = 1'b0;
      pend_err = 1'b0;
      if (m_active) begin
        if (bus.mem_done) begin
          pend = 1'b1;
          m_wc = 0;
        end else if (TO_EN && m_wc == TIMEOUT_CYC) begin
          pend     = 1'b1;
          pend_err = 1'b1;
        end else if (TO_EN) begin
          m_wc++;
        end
      end else if (bus.req_valid) begin
        m_active = 1'b1;
        m_rwb    = bus.req_rwb;
        m_line   = bus.req_rwb && bus.req_line;
        m_adr    = m_line ? {bus.req_adr[12:2], 2'b00} : bus.req_adr;
        m_wdata  = bus.req_wdata;
        m_byteen = bus.req_byteen;
        m_beats  = 0;
        m_wc     = 0;
        if (m_rwb) begin
          for (int i = 0; i < (m_line ? 4 : 1); i++)
            expq.push_back('{ref_mem[m_adr + 13'(i)], (i == (m_line ? 3 : 0)), 1'b0});
        end else begin
          for (int b = 0; b < 4; b++)
            if (m_byteen[b]) ref_mem[m_adr][8*b +: 8] = m_wdata[8*b +: 8];
          expq.push_back('{32'h0, 1'b1, 1'b0});
        end
      end
    end
  end

  // Compare DUT outputs with the model on every cycle.
  always @(negedge ph1) begin
    rsp_t e;
    if (armed) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'(pend));
      if (bus.resp_valid === 1'b1) n_resp++;
      if (pend) begin
        if (pend_err || expq.size() == 0) begin
          e = '{32'h0, 1'b1, 1'b1};
          expq.delete();
        end else begin
          e = expq.pop_front();
        end
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_last", 32'(bus.resp_last), 32'(e.last));
        chk("resp_err",  32'(bus.resp_err),  32'(e.err));
        m_beats++;
        if (e.last) m_active = 1'b0;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(!m_active));
      chk("mem_en",    32'(bus.mem_en),    32'(m_active));
      chk("mem_rwb",   32'(bus.mem_rwb),   32'(m_active ? m_rwb : 1'b1));
      if (m_active) begin
        chk("mem_adr", 32'(bus.mem_adr),
            32'(m_line ? {m_adr[12:2], 2'(m_beats)} : m_adr));
        chk("mem_byteen", 32'(bus.mem_byteen), 32'(m_rwb ? 4'b0000 : m_byteen));
        chk("mem_wdata_oe", 32'(bus.mem_wdata_oe), 32'(!m_rwb));
        if (!m_rwb) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end else begin
        chk("mem_wdata_oe_idle", 32'(bus.mem_wdata_oe), 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge ph1);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 1000) begin
      cyc();
      n++;
    end
    if (m_active) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout t=%0t", $time);
      m_active = 1'b0;
    end
  endtask

  // Presents a request for one edge; returns in the cycle after acceptance.
  task automatic issue(input logic rwb, input logic line, input logic [12:0] adr,
                       input logic [31:0] wdata, input logic [3:0] be);
    wait_idle();
    bus.req_rwb    = rwb;
    bus.req_line   = line;
    bus.req_adr    = adr;
    bus.req_wdata  = wdata;
    bus.req_byteen = be;
    bus.req_valid  = 1'b1;
    cyc();
    bus.req_valid  = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [12:0] line_adr [0:3];
    int base;
    int k;
    line_adr = '{13'h0044, 13'h0045, 13'h0046, 13'h0047};

    for (int a = 0; a < 8192; a++) begin
      bus_mem[a] <= 32'hC0DE0000 | 32'(a);
      ref_mem[a]  = 32'hC0DE0000 | 32'(a);
    end
    bus_mem[13'h0010] <= 32'hDEADBEEF; ref_mem[13'h0010] = 32'hDEADBEEF;
    bus_mem[13'h0044] <= 32'h11110000; ref_mem[13'h0044] = 32'h11110000;
    bus_mem[13'h0045] <= 32'h22220001; ref_mem[13'h0045] = 32'h22220001;
    bus_mem[13'h0046] <= 32'h33330002; ref_mem[13'h0046] = 32'h33330002;
    bus_mem[13'h0047] <= 32'h44440003; ref_mem[13'h0047] = 32'h44440003;
    bus_mem[13'h0020] <= 32'hAABBCCDD; ref_mem[13'h0020] = 32'hAABBCCDD;

    reset_b        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_rwb    = 1'b1;
    bus.req_line   = 1'b0;
    bus.req_adr    = '0;
    bus.req_wdata  = '0;
    bus.req_byteen = '0;
    bus.mem_done   = 1'b1;
    repeat (2) cyc();
    reset_b = 1'b1;
    cyc();

    // reset state
    chk("rst_req_ready",  32'(bus.req_ready),  32'h1);
    chk("rst_mem_en",     32'(bus.mem_en),     32'h0);
    chk("rst_mem_rwb",    32'(bus.mem_rwb),    32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_data",  bus.resp_data,       32'h0);

    // single read, done tied high
    issue(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
    chk("rd_mem_adr", 32'(bus.mem_adr), 32'h0010);
    chk("rd_mem_en",  32'(bus.mem_en),  32'h1);
    cyc();
    chk("rd_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("rd_resp_data",  bus.resp_data,       32'hDEADBEEF);
    chk("rd_resp_last",  32'(bus.resp_last),  32'h1);
    chk("rd_req_ready",  32'(bus.req_ready),  32'h1);

    // back-to-back single read of another word (accepted the very next edge)
    issue(1'b1, 1'b0, 13'h0123, 32'h0, 4'h0);
    wait_idle();

    // line read from an unaligned address
    base = n_resp;
    issue(1'b1, 1'b1, 13'h0047, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("line_mem_adr", 32'(bus.mem_adr), 32'(line_adr[i]));
      cyc();
    end
    chk("line_last_data", bus.resp_data, 32'h44440003);
    chk("line_last_flag", 32'(bus.resp_last), 32'h1);
    repeat (2) cyc();
    chk("line_resp_count", 32'(n_resp - base), 32'd4);

    // byte-enabled write (line flag must be ignored)
    issue(1'b0, 1'b1, 13'h0020, 32'h11223344, 4'b0101);
    chk("wr_mem_rwb", 32'(bus.mem_rwb), 32'h0);
    cyc();
    chk("wr_ack_valid", 32'(bus.resp_valid), 32'h1);
    chk("wr_ack_data",  bus.resp_data,       32'h0);
    chk("wr_rwb_after", 32'(bus.mem_rwb),    32'h1);
    cyc();
    chk("wr_mem_word", bus_mem[13'h0020], 32'hAA22CC44);
    issue(1'b1, 1'b0, 13'h0020, 32'h0, 4'h0);
    wait_idle();

    // line read with beat 1 stretched by three done-low edges
    base = n_resp;
    issue(1'b1, 1'b1, 13'h0044, 32'h0, 4'h0);
    cyc();
    bus.mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_mem_adr", 32'(bus.mem_adr), 32'h0045);
      cyc();
    end
    bus.mem_done = 1'b1;
    chk("stall_mem_adr_end", 32'(bus.mem_adr), 32'h0045);
    wait_idle();
    repeat (2) cyc();
    chk("stall_resp_count", 32'(n_resp - base), 32'd4);

    // reset after beat 1 of a line read
    base = n_resp;
    issue(1'b1, 1'b1, 13'h0044, 32'h0, 4'h0);
    repeat (2) cyc();
    reset_b = 1'b0;
    cyc();
    chk("mid_rst_mem_en",     32'(bus.mem_en),     32'h0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("mid_rst_req_ready",  32'(bus.req_ready),  32'h1);
    reset_b = 1'b1;
    repeat (4) cyc();
    chk("mid_rst_resp_count", 32'(n_resp - base), 32'd2);

`ifdef EXTMEM_CTRL_TIMEOUT_EN
    // done stuck low: abort after the wait counter saturates
    bus.mem_done = 1'b0;
    issue(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
    k = 0;
    while (bus.resp_valid !== 1'b1 && k < 400) begin
      cyc();
      k++;
    end
    chk("to_cycles",    32'(k),             32'd256);
    chk("to_resp_err",  32'(bus.resp_err),  32'h1);
    chk("to_resp_last", 32'(bus.resp_last), 32'h1);
    chk("to_resp_data", bus.resp_data,      32'h0);
    bus.mem_done = 1'b1;
    cyc();
    chk("to_idle_ready", 32'(bus.req_ready), 32'h1);
`else
    // done held low: the beat simply waits
    base = n_resp;
    bus.mem_done = 1'b0;
    issue(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
    k = 0;
    repeat (20) begin
      cyc();
      k++;
    end
    chk("wait_no_resp", 32'(n_resp - base), 32'd0);
    chk("wait_mem_en",  32'(bus.mem_en),    32'h1);
    bus.mem_done = 1'b1;
    wait_idle();
    cyc();
    chk("wait_resp_count", 32'(n_resp - base), 32'd1);
`endif

    // final sanity read after everything
    issue(1'b1, 1'b1, 13'h0046, 32'h0, 4'h0);
    wait_idle();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
